// File: rtl/pass_check_lock_if.sv
// Button/status bus of the password checker.
// The code-programming signals exist only when PASS_CHECK_LOCK_CODE_PROG_EN is defined.
interface pass_check_lock_if #(
  parameter int CODE_LEN  = 4,
  parameter int MAX_FAILS = 3
);
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int DW = $clog2(CODE_LEN + 1);

  logic          button_1;
  logic          button_0;
  logic          unlock;
  logic          locked_out;
  logic [FW-1:0] fail_cnt;
  logic [DW-1:0] digit_cnt;
`ifdef PASS_CHECK_LOCK_CODE_PROG_EN
  logic                prog_we;
  logic [CODE_LEN-1:0] prog_code;
`endif

  modport master (
    output button_1, button_0,
`ifdef PASS_CHECK_LOCK_CODE_PROG_EN
    output prog_we, prog_code,
`endif
    input  unlock, locked_out, fail_cnt, digit_cnt
  );

  modport slave (
    input  button_1, button_0,
`ifdef PASS_CHECK_LOCK_CODE_PROG_EN
    input  prog_we, prog_code,
`endif
    output unlock, locked_out, fail_cnt, digit_cnt
  );
endinterface

// File: rtl/pass_check_lock.sv
// Parametrised button password checker with failure lockout.
// Collects CODE_LEN digits (MSB first), opens for UNLOCK_CYCLES on a match and
// locks out for LOCK_CYCLES after MAX_FAILS consecutive wrong entries.
// Optional macro PASS_CHECK_LOCK_CODE_PROG_EN adds a code register writable in OPEN.
module pass_check_lock #(
  parameter int                  CODE_LEN      = 4,
  parameter logic [CODE_LEN-1:0] CODE          = 4'b1011,
  parameter int                  MAX_FAILS     = 3,
  parameter int                  LOCK_CYCLES   = 16,
  parameter int                  UNLOCK_CYCLES = 8,
  parameter int                  ENTRY_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  pass_check_lock_if.slave bus
);
  localparam int FW     = $clog2(MAX_FAILS + 1);
  localparam int DW     = $clog2(CODE_LEN + 1);
  localparam int TMAX_A = (LOCK_CYCLES > UNLOCK_CYCLES) ? LOCK_CYCLES : UNLOCK_CYCLES;
  localparam int TMAX   = (TMAX_A > ENTRY_TIMEOUT) ? TMAX_A : ENTRY_TIMEOUT;
  localparam int TW     = $clog2(TMAX) + 1;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_ENTRY = 2'b01;
  localparam logic [1:0] S_OPEN  = 2'b10;
  localparam logic [1:0] S_LOCK  = 2'b11;

  // Timers count down to zero; the reload value is duration-1 so the
  // terminal cycle is the one that sees zero.
  localparam logic [TW-1:0] T_UNLOCK = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK   = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] T_ENTRY  = TW'(ENTRY_TIMEOUT - 1);
  localparam logic [FW-1:0] F_MAX    = FW'(MAX_FAILS);
  localparam logic [DW-1:0] D_LEN    = DW'(CODE_LEN);

  logic [1:0]          state_q, state_d;
  logic [CODE_LEN-1:0] shift_q, shift_d;
  logic                inv_q, inv_d;
  logic [DW-1:0]       digit_q, digit_d;
  logic [FW-1:0]       fail_q, fail_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                unlock_q, unlock_d;
  logic                lock_q, lock_d;

  logic [CODE_LEN-1:0] code_s;
  logic                press_s;
  logic                both_s;
  logic [CODE_LEN-1:0] base_shift_s;
  logic                base_inv_s;
  logic [CODE_LEN-1:0] entry_s;
  logic                inv_next_s;
  logic [DW-1:0]       cnt_inc_s;
  logic [FW-1:0]       fail_inc_s;

  assign press_s = bus.button_1 | bus.button_0;
  assign both_s  = bus.button_1 & bus.button_0;

  // An entry starts from a clean slate in IDLE, so the first press is handled
  // exactly like later ones (this also covers CODE_LEN == 1).
  assign base_shift_s = (state_q == S_IDLE) ? {CODE_LEN{1'b0}} : shift_q;
  assign base_inv_s   = (state_q == S_IDLE) ? 1'b0 : inv_q;
  assign entry_s      = (base_shift_s << 1) | CODE_LEN'(bus.button_1);
  assign inv_next_s   = base_inv_s | both_s;
  assign cnt_inc_s    = ((state_q == S_IDLE) ? {DW{1'b0}} : digit_q) + DW'(1);
  // fail_q is below MAX_FAILS whenever an entry is judged, so this never overflows.
  assign fail_inc_s   = fail_q + FW'(1);

`ifdef PASS_CHECK_LOCK_CODE_PROG_EN
  logic [CODE_LEN-1:0] code_q, code_d;

  // Code reload is accepted only while the door is open.
  always_comb begin
    if ((state_q == S_OPEN) && bus.prog_we) begin
      code_d = bus.prog_code;
    end else begin
      code_d = code_q;
    end
  end

  // Code register, back to the default code on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      code_q <= CODE;
    end else begin
      code_q <= code_d;
    end
  end

  assign code_s = code_q;
`else
  assign code_s = CODE;
`endif

  // Next-state logic: digit collection, judging, and timed OPEN/LOCKOUT.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    inv_d    = inv_q;
    digit_d  = digit_q;
    fail_d   = fail_q;
    tmr_d    = tmr_q;
    unlock_d = 1'b0;
    lock_d   = 1'b0;
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (press_s) begin
          if (cnt_inc_s == D_LEN) begin
            shift_d = {CODE_LEN{1'b0}};
            inv_d   = 1'b0;
            digit_d = {DW{1'b0}};
            if (!inv_next_s && (entry_s == code_s)) begin
              state_d  = S_OPEN;
              fail_d   = {FW{1'b0}};
              tmr_d    = T_UNLOCK;
              unlock_d = 1'b1;
            end else if (fail_inc_s >= F_MAX) begin
              state_d = S_LOCK;
              fail_d  = F_MAX;
              tmr_d   = T_LOCK;
              lock_d  = 1'b1;
            end else begin
              state_d = S_IDLE;
              fail_d  = fail_inc_s;
              tmr_d   = {TW{1'b0}};
            end
          end else begin
            state_d = S_ENTRY;
            shift_d = entry_s;
            inv_d   = inv_next_s;
            digit_d = cnt_inc_s;
            tmr_d   = T_ENTRY;
          end
        end else if (state_q == S_ENTRY) begin
          if (tmr_q == {TW{1'b0}}) begin
            // Inactivity: drop the partial entry without counting a failure.
            state_d = S_IDLE;
            shift_d = {CODE_LEN{1'b0}};
            inv_d   = 1'b0;
            digit_d = {DW{1'b0}};
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OPEN: begin
        if (tmr_q == {TW{1'b0}}) begin
          state_d = S_IDLE;
        end else begin
          tmr_d    = tmr_q - TW'(1);
          unlock_d = 1'b1;
        end
      end
      S_LOCK: begin
        if (tmr_q == {TW{1'b0}}) begin
          state_d = S_IDLE;
          fail_d  = {FW{1'b0}};
        end else begin
          tmr_d  = tmr_q - TW'(1);
          lock_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        shift_d = {CODE_LEN{1'b0}};
        inv_d   = 1'b0;
        digit_d = {DW{1'b0}};
        fail_d  = {FW{1'b0}};
        tmr_d   = {TW{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shift_q  <= {CODE_LEN{1'b0}};
      inv_q    <= 1'b0;
      digit_q  <= {DW{1'b0}};
      fail_q   <= {FW{1'b0}};
      tmr_q    <= {TW{1'b0}};
      unlock_q <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      inv_q    <= inv_d;
      digit_q  <= digit_d;
      fail_q   <= fail_d;
      tmr_q    <= tmr_d;
      unlock_q <= unlock_d;
      lock_q   <= lock_d;
    end
  end

  assign bus.unlock     = unlock_q;
  assign bus.locked_out = lock_q;
  assign bus.fail_cnt   = fail_q;
  assign bus.digit_cnt  = digit_q;
endmodule

// File: tb/tb_pass_check_lock.sv
// Scoreboard bench for pass_check_lock: directed test-plan scenarios followed by
// random button traffic, checked every cycle against a digit-list reference model.
module tb_pass_check_lock;
  localparam int              CODE_LEN      = 4;
  localparam logic [3:0]      CODE          = 4'b1011;
  localparam int              MAX_FAILS     = 3;
  localparam int              LOCK_CYCLES   = 16;
  localparam int              UNLOCK_CYCLES = 8;
  localparam int              ENTRY_TIMEOUT = 16;
  localparam int              FW = $clog2(MAX_FAILS + 1);
  localparam int              DW = $clog2(CODE_LEN + 1);
`ifdef PASS_CHECK_LOCK_CODE_PROG_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  localparam int M_IDLE = 0, M_ENTRY = 1, M_OPEN = 2, M_LOCK = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pass_check_lock_if #(.CODE_LEN(CODE_LEN), .MAX_FAILS(MAX_FAILS)) bus ();

  pass_check_lock #(
    .CODE_LEN(CODE_LEN), .CODE(CODE), .MAX_FAILS(MAX_FAILS),
    .LOCK_CYCLES(LOCK_CYCLES), .UNLOCK_CYCLES(UNLOCK_CYCLES),
    .ENTRY_TIMEOUT(ENTRY_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int unlock;
    int locked_out;
    int fail;
    int digits;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: the entry is a list of digits (2 marks an invalid press).
  int                  m_mode = M_IDLE;
  int                  m_digits[$];
  int                  m_idle = 0;
  int                  m_left = 0;
  int                  m_fail = 0;
  logic [CODE_LEN-1:0] m_code = CODE;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic b1, input logic b0, input logic r,
                            input logic pwe, input logic [CODE_LEN-1:0] pc);
    bit ok;
    if (r) begin
      m_mode = M_IDLE; m_digits.delete(); m_idle = 0; m_left = 0; m_fail = 0;
      m_code = CODE;
    end else begin
      case (m_mode)
        M_IDLE, M_ENTRY: begin
          if (b1 || b0) begin
            m_digits.push_back((b1 && b0) ? 2 : (b1 ? 1 : 0));
            m_idle = 0;
            m_mode = M_ENTRY;
            if (m_digits.size() == CODE_LEN) begin
              ok = 1'b1;
              for (int i = 0; i < CODE_LEN; i++)
                if (m_digits[i] != int'(m_code[CODE_LEN-1-i])) ok = 1'b0;
              m_digits.delete();
              if (ok) begin
                m_mode = M_OPEN; m_left = UNLOCK_CYCLES; m_fail = 0;
              end else begin
                m_fail = (m_fail + 1 > MAX_FAILS) ? MAX_FAILS : m_fail + 1;
                if (m_fail == MAX_FAILS) begin
                  m_mode = M_LOCK; m_left = LOCK_CYCLES;
                end else begin
                  m_mode = M_IDLE;
                end
              end
            end
          end else if (m_mode == M_ENTRY) begin
            m_idle++;
            if (m_idle >= ENTRY_TIMEOUT) begin
              m_mode = M_IDLE; m_digits.delete();
            end
          end
        end
        M_OPEN: begin
          if (PROG && pwe) m_code = pc;
          m_left--;
          if (m_left == 0) m_mode = M_IDLE;
        end
        default: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_IDLE; m_fail = 0;
          end
        end
      endcase
    end
  endtask

  // One clock of stimulus: drive on the falling edge, predict the post-edge outputs.
  task automatic cycle(input logic b1, input logic b0, input logic r,
                       input logic pwe, input logic [CODE_LEN-1:0] pc);
    exp_t e;
    @(negedge clk);
    reset        = r;
    bus.button_1 = b1;
    bus.button_0 = b0;
`ifdef PASS_CHECK_LOCK_CODE_PROG_EN
    bus.prog_we   = pwe;
    bus.prog_code = pc;
`endif
    model_step(b1, b0, r, pwe, pc);
    e.unlock     = (m_mode == M_OPEN) ? 1 : 0;
    e.locked_out = (m_mode == M_LOCK) ? 1 : 0;
    e.fail       = m_fail;
    e.digits     = m_digits.size();
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic press(input logic b);
    cycle(b, ~b, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic enter(input logic [CODE_LEN-1:0] c);
    for (int i = CODE_LEN - 1; i >= 0; i--) begin
      press(c[i]);
      idle(1);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("unlock",     int'(bus.unlock),     e.unlock);
        chk("locked_out", int'(bus.locked_out), e.locked_out);
        chk("fail_cnt",   int'(bus.fail_cnt),   e.fail);
        chk("digit_cnt",  int'(bus.digit_cnt),  e.digits);
      end
    end
  end

  initial begin
    int r;
    reset        = 1'b1;
    bus.button_1 = 1'b0;
    bus.button_0 = 1'b0;
`ifdef PASS_CHECK_LOCK_CODE_PROG_EN
    bus.prog_we   = 1'b0;
    bus.prog_code = '0;
`endif
    do_reset();
    do_reset();

    // Correct entry, full unlock window.
    idle(7);
    enter(4'b1011);
    idle(12);
    // One wrong entry, then a correct one clears the failure count.
    enter(4'b1010);
    idle(2);
    enter(4'b1011);
    idle(12);
    // Three wrong entries -> lockout; correct code during lockout is ignored.
    enter(4'b0000);
    enter(4'b0000);
    enter(4'b0000);
    enter(4'b1011);
    idle(12);
    enter(4'b1011);
    idle(12);
    // Partial entry times out.
    press(1'b1);
    idle(1);
    press(1'b0);
    idle(20);
    enter(4'b1011);
    idle(12);
    // Both buttons as the second digit makes the entry invalid.
    press(1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    press(1'b1);
    press(1'b1);
    idle(3);
    // Reset on the third cycle of OPEN.
    enter(4'b1011);
    idle(1);
    do_reset();
    idle(3);
    // Reset in the middle of a lockout.
    enter(4'b0000);
    enter(4'b0000);
    enter(4'b0000);
    idle(5);
    do_reset();
    idle(3);

`ifdef PASS_CHECK_LOCK_CODE_PROG_EN
    // Reprogram while open, check new and old codes.
    enter(4'b1011);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
    idle(10);
    enter(4'b0110);
    idle(10);
    enter(4'b1011);
    idle(3);
    // Write attempt in IDLE is ignored.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111);
    enter(4'b0110);
    idle(10);
    // Reset restores the default code.
    do_reset();
    enter(4'b1011);
    idle(10);
`endif

    // Random traffic with occasional correct entries and resets.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        enter(m_code);
      end else if (r < 3) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
              1'b0,
              ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
              CODE_LEN'($urandom));
      end
    end

    idle(2);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pass_check_lock.md
Name: pass_check_lock

Overview:
- Parametrised successor to the team's fixed 4-digit button password checker.
- Collects a CODE_LEN-digit sequence from two push-button strobes and compares it to a stored code. Asserts unlock for a programmable hold time on a match.
- Counts consecutive failures and enters a timed lockout after MAX_FAILS wrong entries.
- Sits behind the button debounce/edge-detect stage; drives the door actuator and the status LEDs.

Parameters:
- CODE_LEN, 4: number of digits per entry.
- CODE, 4'b1011: reset/default code, CODE_LEN bits; MSB is the first digit entered.
- MAX_FAILS, 3: consecutive wrong entries that trigger lockout (>=1).
- LOCK_CYCLES, 16: lockout duration in clk cycles (>=1).
- UNLOCK_CYCLES, 8: unlock hold duration in clk cycles (>=1).
- ENTRY_TIMEOUT, 16: idle cycles allowed between digits before a partial entry is discarded (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- button_1  in  1  single-cycle strobe, digit '1'.
- button_0  in  1  single-cycle strobe, digit '0'.
- unlock  out  1  high while the lock is open.
- locked_out  out  1  high during lockout.
- fail_cnt  out  $clog2(MAX_FAILS+1)  current consecutive-failure count.
- digit_cnt  out  $clog2(CODE_LEN+1)  digits captured in the current entry.
- prog_we  in  1  code write strobe (CODE_PROG_EN only).
- prog_code  in  CODE_LEN  new code value (CODE_PROG_EN only).

Behaviour:
- All outputs are registered. Reset (sampled at a clk edge with reset=1) forces:
  - state=IDLE, unlock=0, locked_out=0, fail_cnt=0, digit_cnt=0;
  - all timers to 0; the code register to CODE.
  - Reset wins over every other event, including mid-OPEN and mid-LOCKOUT; unlock/locked_out drop the cycle after reset is sampled.
- Press definition: a cycle in which button_1 or button_0 is high.
  - Digit value = button_1 when exactly one button is high.
  - Both high = invalid digit. It is shifted in and forces a mismatch for that entry.
- States:
  - IDLE:
    - A press captures digit 1 into the shift register (MSB-first), sets digit_cnt=1 and goes to ENTRY.
    - With CODE_LEN=1, the press is judged immediately (see ENTRY judging rule).
  - ENTRY:
    - Each press shifts in a digit and increments digit_cnt.
    - A press resets the inactivity timer. ENTRY_TIMEOUT consecutive cycles without a press -> IDLE, digits discarded, digit_cnt=0, fail_cnt unchanged.
    - On the press that makes digit_cnt==CODE_LEN, judge the entry:
      - Match and no invalid digit -> OPEN, fail_cnt=0.
      - Otherwise fail_cnt+1. If the new value ==MAX_FAILS -> LOCKOUT, else -> IDLE.
    - digit_cnt returns to 0 on judging.
    - No early abort on a wrong digit: all CODE_LEN digits are always collected.
  - OPEN:
    - unlock=1 from the cycle after the judging press, for exactly UNLOCK_CYCLES cycles, then IDLE.
    - Presses are ignored.
  - LOCKOUT:
    - locked_out=1 from the cycle after the judging press, for exactly LOCK_CYCLES cycles.
    - Presses are ignored.
    - Exit -> IDLE with fail_cnt=0.
- fail_cnt saturates at MAX_FAILS. It clears only on a correct entry, on lockout exit, or on reset.
- Timers are sized $clog2 of the largest of LOCK_CYCLES, UNLOCK_CYCLES and ENTRY_TIMEOUT, plus 1. There is no wrap: each timer is reloaded on state entry.
- Illegal state encoding -> IDLE next cycle, outputs 0.

Optional Feature:
- Macro: PASS_CHECK_LOCK_CODE_PROG_EN.
- Defined:
  - Ports prog_we and prog_code exist. The code is held in a CODE_LEN-bit register, reset to CODE.
  - prog_we is honoured only in OPEN. The register takes prog_code at that edge and the new code applies from the next entry.
  - prog_we in any other state is ignored.
- Undefined:
  - Ports are absent and the code is the constant CODE.

Test Plan:
- Reset, then presses 1,0,1,1 on cycles 10,12,14,16 -> unlock=1 on cycles 17..24, 0 at 25; fail_cnt=0 throughout.
- Presses 1,0,1,0 -> unlock stays 0, fail_cnt=1, state IDLE; next entry 1,0,1,1 -> unlock, fail_cnt=0.
- Three wrong entries (0000 x3) -> locked_out=1 for 16 cycles starting the cycle after the 12th press; 1,0,1,1 pressed during lockout -> no unlock; after exit fail_cnt=0 and 1,0,1,1 unlocks.
- Timeout: presses 1,0, then 20 idle cycles -> digit_cnt=0 at cycle 16 after the last press, fail_cnt=0; a following 1,0,1,1 unlocks. Separately, an entry with both buttons high as the 2nd digit -> fail_cnt=1.
- Reset asserted on the 3rd cycle of OPEN -> unlock=0 the next cycle, all counters 0; reset mid-LOCKOUT -> locked_out=0 the next cycle.
- With PASS_CHECK_LOCK_CODE_PROG_EN:
  - In OPEN, prog_we=1 with prog_code=4'b0110 -> 0,1,1,0 unlocks and 1,0,1,1 fails.
  - prog_we in IDLE -> code unchanged.
  - Reset -> code reverts to 1011.
